// File: rtl/retire_trace_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : retire_trace_serializer_pkg
// Brief   : Shared trace-record layout and helpers for the retire trace port.
// Revision: 1.0 - initial release
// ============================================================================
package retire_trace_serializer_pkg;

    // inst_retire record layout: {rf_en, waddr, wdata, pc}
    localparam int unsigned RETIRE_W    = 70;
    localparam int unsigned RT_RFEN     = 69;
    localparam int unsigned RT_WADDR_HI = 68;
    localparam int unsigned RT_WADDR_LO = 64;
    localparam int unsigned RT_WDATA_HI = 63;
    localparam int unsigned RT_WDATA_LO = 32;
    localparam int unsigned RT_PC_HI    = 31;
    localparam int unsigned RT_PC_LO    = 0;

    // Queued entries always have rf_en=1, so the FIFO drops that bit.
    localparam int unsigned FIFO_W      = RETIRE_W - 1;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } rt_entry_t;

    // A slot produces a trace record only if it really writes a non-zero register.
    function automatic logic rt_qualifies(input logic eff, input logic wen,
                                          input logic [4:0] waddr);
        return eff && wen && (waddr != 5'd0);
    endfunction

endpackage : retire_trace_serializer_pkg
`default_nettype wire

// File: rtl/retire_fifo.sv
`default_nettype none
// ============================================================================
// Module  : retire_fifo
// Brief   : DEPTH-entry FIFO with two write ports (port 0 older) and one
//           read port; exposes occupancy for flow control.
// Revision: 1.0 - initial release
// ============================================================================
module retire_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 69
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push0,
    input  logic [W-1:0]               i_data0,
    input  logic                       i_push1,
    input  logic [W-1:0]               i_data1,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_occ;
    logic [PTR_W-1:0] w_wr1_ptr;

    // Port 1 lands behind port 0 when both write in the same cycle.
    assign w_wr1_ptr = i_push0 ? (r_tail + PTR_W'(1)) : r_tail;

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_tail]    <= i_data0;
        if (i_push1) r_mem[w_wr1_ptr] <= i_data1;
    end

    // Pointer and occupancy bookkeeping; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + PTR_W'(i_pop);
            r_tail <= r_tail + PTR_W'(i_push0) + PTR_W'(i_push1);
            r_occ  <= r_occ + (PTR_W+1)'(i_push0) + (PTR_W+1)'(i_push1)
                            - (PTR_W+1)'(i_pop);
        end
    end

    assign o_head      = r_mem[r_head];
    assign o_occupancy = r_occ;

endmodule : retire_fifo
`default_nettype wire

// File: rtl/retire_trace_serializer.sv
`default_nettype none
// ============================================================================
// Module  : retire_trace_serializer
// Brief   : Serialises up to two retiring instructions per cycle into one
//           register-write trace record per cycle, in program order, and
//           counts retired instructions.
// Revision: 1.0 - initial release
// ============================================================================
module retire_trace_serializer
    import retire_trace_serializer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb0_valid,
    input  logic [31:0]          wb0_pc,
    input  logic                 wb0_rf_wen,
    input  logic [4:0]           wb0_waddr,
    input  logic [31:0]          wb0_wdata,
    input  logic                 wb1_valid,
    input  logic [31:0]          wb1_pc,
    input  logic                 wb1_rf_wen,
    input  logic [4:0]           wb1_waddr,
    input  logic [31:0]          wb1_wdata,
    output logic                 wb_ready,
    output logic [RETIRE_W-1:0]  inst_retire,
    output logic [CNT_W-1:0]     retired_cnt,
    output logic                 err_overflow,
    output logic                 err_order
);

    localparam int             PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_READY_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W:0]      w_occ;
    logic                w_ready;
    logic                w_eff0;
    logic                w_eff1;
    logic                w_q0;
    logic                w_q1;
    rt_entry_t           w_ent0;
    rt_entry_t           w_ent1;
    rt_entry_t           w_head;
    rt_entry_t           w_sel;
    logic                w_sel_en;
    logic                w_pop;
    logic                w_push0;
    logic                w_push1;
    rt_entry_t           w_data0;
    logic [RETIRE_W-1:0] w_next;

    logic [RETIRE_W-1:0] r_inst_retire;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err_overflow;
    logic                r_err_order;

    // Up to two pushes against one pop means DEPTH-2 is the last safe level.
    assign w_ready = (w_occ <= c_READY_MAX);

    // wb1 is only honoured behind a valid wb0; both are gated by flow control.
    assign w_eff0 = wb0_valid && w_ready;
    assign w_eff1 = wb1_valid && wb0_valid && w_ready;
    assign w_q0   = rt_qualifies(w_eff0, wb0_rf_wen, wb0_waddr);
    assign w_q1   = rt_qualifies(w_eff1, wb1_rf_wen, wb1_waddr);

    assign w_ent0 = '{waddr: wb0_waddr, wdata: wb0_wdata, pc: wb0_pc};
    assign w_ent1 = '{waddr: wb1_waddr, wdata: wb1_wdata, pc: wb1_pc};

    // Pick the oldest record (FIFO head, wb0, wb1) for output; the rest is
    // compacted onto FIFO write port 0 first so port 1 only ever carries wb1.
    always_comb begin
        w_sel_en = 1'b0;
        w_sel    = '0;
        w_pop    = 1'b0;
        w_push0  = 1'b0;
        w_push1  = 1'b0;
        w_data0  = w_ent0;
        if (w_occ != '0) begin
            w_sel_en = 1'b1;
            w_sel    = w_head;
            w_pop    = 1'b1;
            w_push0  = w_q0 || w_q1;
            w_data0  = w_q0 ? w_ent0 : w_ent1;
            w_push1  = w_q0 && w_q1;
        end else if (w_q0) begin
            w_sel_en = 1'b1;
            w_sel    = w_ent0;
            w_push0  = w_q1;
            w_data0  = w_ent1;
        end else if (w_q1) begin
            w_sel_en = 1'b1;
            w_sel    = w_ent1;
        end
    end

    // Assemble the trace record; an idle cycle emits all zeros.
    always_comb begin
        w_next = '0;
        if (w_sel_en) begin
            w_next[RT_RFEN]                 = 1'b1;
            w_next[RT_WADDR_HI:RT_WADDR_LO] = w_sel.waddr;
            w_next[RT_WDATA_HI:RT_WDATA_LO] = w_sel.wdata;
            w_next[RT_PC_HI:RT_PC_LO]       = w_sel.pc;
        end
    end

    retire_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push0     (w_push0),
        .i_data0     (w_data0),
        .i_push1     (w_push1),
        .i_data1     (w_ent1),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occupancy (w_occ)
    );

    // Output register, retired-instruction counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_retire  <= '0;
            r_cnt          <= '0;
            r_err_overflow <= 1'b0;
            r_err_order    <= 1'b0;
        end else begin
            r_inst_retire <= w_next;
            r_cnt         <= r_cnt + CNT_W'(w_eff0) + CNT_W'(w_eff1);
            if (!w_ready && (wb0_valid || wb1_valid)) r_err_overflow <= 1'b1;
            if (wb1_valid && !wb0_valid)              r_err_order    <= 1'b1;
        end
    end

    assign wb_ready     = w_ready;
    assign inst_retire  = r_inst_retire;
    assign retired_cnt  = r_cnt;
    assign err_overflow = r_err_overflow;
    assign err_order    = r_err_order;

endmodule : retire_trace_serializer
`default_nettype wire
